// File: rtl/vga_fb_pkg.sv
// Shared constants, types and helpers for the VGA framebuffer arbiter.
// Defaults describe a 640x480 8-bit framebuffer; instances may override them.
package vga_fb_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned FB_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned DATA_W   = 8;

  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef logic [DATA_W-1:0] pix_t;

  // Owner of a RAM cycle; also used as the return tag for read data.
  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_SCAN = 2'd1,
    SLOT_HWR  = 2'd2,
    SLOT_HRD  = 2'd3
  } slot_e;

  // Vsync is active low, so a frame begins on its falling edge.
  function automatic logic is_frame_start(input logic vs_prev, input logic vs_now);
    return vs_prev && !vs_now;
  endfunction

endpackage

// File: rtl/vga_fb_scan_ctrl.sv
// Scanout address generation and front/back bank control: vsync edge detect,
// saturating scan counter with sticky overrun, and frame-aligned bank swap.
module vga_fb_scan_ctrl
  import vga_fb_pkg::*;
#(
  parameter int unsigned FB_WORDS = vga_fb_pkg::FB_WORDS,
  parameter int unsigned ADDR_W   = vga_fb_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vs_i,
  input  logic              scan_i,
  input  logic              swap_req_i,
  output logic [ADDR_W-1:0] scan_addr_o,
  output logic              front_o,
  output logic              swap_ack_o,
  output logic              overrun_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_WORDS - 1);

  logic              vs_d_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              pend_q, pend_d;
  logic              front_q, front_d;
  logic              ack_q, ack_d;
  logic              frame_start;

  always_comb begin
    frame_start = is_frame_start(vs_d_q, vs_i);
    // A scan slot landing on frame start already uses the cleared address.
    scan_addr_o = frame_start ? '0 : cnt_q;

    cnt_d = cnt_q;
    ovr_d = ovr_q;
    if (frame_start) begin
      cnt_d = scan_i ? ADDR_W'(1) : '0;
    end else if (scan_i) begin
      if (cnt_q == LastAddr) begin
        ovr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end

    // A request seen in the frame-start cycle re-arms pending for the next frame.
    ack_d   = frame_start && pend_q;
    front_d = front_q ^ ack_d;
    pend_d  = (pend_q && !frame_start) || swap_req_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_d_q  <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
      front_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      vs_d_q  <= vs_i;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
      front_q <= front_d;
      ack_q   <= ack_d;
    end
  end

  assign front_o    = front_q;
  assign swap_ack_o = ack_q;
  assign overrun_o  = ovr_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout owns active-area cycles, the
// host read/write ports share blanking cycles round-robin on the back bank.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_fb_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = vga_fb_pkg::V_ACTIVE,
  parameter int unsigned FB_WORDS = H_ACTIVE * V_ACTIVE,
  parameter int unsigned ADDR_W   = vga_fb_pkg::ADDR_W,
  parameter int unsigned DATA_W   = vga_fb_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_vs,
  input  logic              i_activeArea,
  input  logic              i_wrValid,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  output logic              o_wrReady,
  input  logic              i_rdValid,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic              o_rdReady,
  output logic [DATA_W-1:0] o_rdData,
  output logic              o_rdDataValid,
  input  logic              i_swapReq,
  output logic              o_swapAck,
  output logic              o_frontBank,
  output logic [ADDR_W:0]   o_memAddr,
  output logic              o_memWe,
  output logic [DATA_W-1:0] o_memWdata,
  input  logic [DATA_W-1:0] i_memRdata,
  output logic [DATA_W-1:0] o_pixel,
  output logic              o_pixelValid,
  output logic              o_scanOverrun
);

  logic              running_q;
  logic              rr_q, rr_d;
  logic              host_cycle, wr_grant, rd_grant;
  slot_e             slot;
  slot_e             tag1_q, tag2_q;

  logic [ADDR_W-1:0] scan_addr;
  logic              front;

  logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [DATA_W-1:0] pixel_q, pixel_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  vga_fb_scan_ctrl #(
    .FB_WORDS (FB_WORDS),
    .ADDR_W   (ADDR_W)
  ) u_scan_ctrl (
    .clk_i       (i_clk),
    .rst_ni      (i_reset_n),
    .vs_i        (i_vs),
    .scan_i      (i_activeArea),
    .swap_req_i  (i_swapReq),
    .scan_addr_o (scan_addr),
    .front_o     (front),
    .swap_ack_o  (o_swapAck),
    .overrun_o   (o_scanOverrun)
  );

  // rr_q = 0 favours the write port when both host requests collide.
  always_comb begin
    host_cycle = !i_activeArea && running_q;
    wr_grant   = host_cycle && i_wrValid && (!i_rdValid || !rr_q);
    rd_grant   = host_cycle && i_rdValid && (!i_wrValid || rr_q);
    rr_d       = rr_q ^ (wr_grant || rd_grant);

    slot = SLOT_IDLE;
    if (i_activeArea) begin
      slot = SLOT_SCAN;
    end else if (wr_grant) begin
      slot = SLOT_HWR;
    end else if (rd_grant) begin
      slot = SLOT_HRD;
    end
  end

  // Host traffic always targets the bank not being scanned out this cycle.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    unique case (slot)
      SLOT_SCAN: mem_addr_d = {front, scan_addr};
      SLOT_HWR: begin
        mem_addr_d  = {~front, i_wrAddr};
        mem_we_d    = 1'b1;
        mem_wdata_d = i_wrData;
      end
      SLOT_HRD:  mem_addr_d = {~front, i_rdAddr};
      default: ;
    endcase
  end

  always_comb begin
    pixel_d       = '0;
    pixel_valid_d = 1'b0;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    unique case (tag2_q)
      SLOT_SCAN: begin
        pixel_d       = i_memRdata;
        pixel_valid_d = 1'b1;
      end
      SLOT_HRD: begin
        rd_data_d  = i_memRdata;
        rd_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      running_q     <= 1'b0;
      rr_q          <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      tag1_q        <= SLOT_IDLE;
      tag2_q        <= SLOT_IDLE;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      running_q     <= 1'b1;
      rr_q          <= rr_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      tag1_q        <= slot;
      tag2_q        <= tag1_q;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign o_wrReady     = wr_grant;
  assign o_rdReady     = rd_grant;
  assign o_frontBank   = front;
  assign o_memAddr     = mem_addr_q;
  assign o_memWe       = mem_we_q;
  assign o_memWdata    = mem_wdata_q;
  assign o_pixel       = pixel_q;
  assign o_pixelValid  = pixel_valid_q;
  assign o_rdData      = rd_data_q;
  assign o_rdDataValid = rd_valid_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter on a reduced 8x4 framebuffer,
// with a behavioural RAM and a cycle-level reference model.
module tb_vga_fb_arbiter;

  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned FB = H * V;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          vs = 1'b1, act = 1'b0;
  logic          wv = 1'b0, rv = 1'b0, swq = 1'b0;
  logic [AW-1:0] wa = '0, ra = '0;
  logic [DW-1:0] wd = '0;
  logic          wr_ready, rd_ready, rd_dv, swap_ack, front, mem_we, pixel_valid, overrun;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata, pixel;
  logic [AW:0]   mem_addr;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .DATA_W   (DW)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_vs          (vs),
    .i_activeArea  (act),
    .i_wrValid     (wv),
    .i_wrAddr      (wa),
    .i_wrData      (wd),
    .o_wrReady     (wr_ready),
    .i_rdValid     (rv),
    .i_rdAddr      (ra),
    .o_rdReady     (rd_ready),
    .o_rdData      (rd_data),
    .o_rdDataValid (rd_dv),
    .i_swapReq     (swq),
    .o_swapAck     (swap_ack),
    .o_frontBank   (front),
    .o_memAddr     (mem_addr),
    .o_memWe       (mem_we),
    .o_memWdata    (mem_wdata),
    .i_memRdata    (mem_rdata),
    .o_pixel       (pixel),
    .o_pixelValid  (pixel_valid),
    .o_scanOverrun (overrun)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 29 + 7);
  endfunction

  // Synchronous RAM, read data one cycle after the address; seeded on first edge.
  logic [DW-1:0] ram [0:2*FB-1];
  bit            ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 2 * FB; i++) ram[i] <= pat(i);
      ram_init <= 1'b1;
    end else begin
      mem_rdata <= ram[int'({mem_addr[AW], mem_addr[IW-1:0]})];
      if (mem_we) ram[int'({mem_addr[AW], mem_addr[IW-1:0]})] <= mem_wdata;
    end
  end

  int n_vec = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model state
  logic [DW-1:0] mm [0:2*FB-1];
  bit            m_vsd, m_pend, m_front, m_rr, m_run, m_ovr;
  int            m_cnt;
  logic [AW:0]   m_last;
  bit            s_pv [8];
  bit            s_rv [8];
  logic [DW-1:0] s_px [8];
  logic [DW-1:0] s_rd [8];
  bit            got_w, got_r;

  task automatic model_reset();
    m_vsd = 0; m_pend = 0; m_front = 0; m_rr = 0; m_run = 0; m_ovr = 0;
    m_cnt = 0; m_last = '0;
    for (int i = 0; i < 8; i++) begin
      s_pv[i] = 0; s_rv[i] = 0; s_px[i] = '0; s_rd[i] = '0;
    end
  endtask

  task automatic step();
    bit            fs, gw, gr, ack, e_we;
    int            saddr, due, idx;
    logic [AW:0]   e_addr;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    fs = m_vsd && !vs;
    gw = !act && m_run && wv && (!rv || !m_rr);
    gr = !act && m_run && rv && (!wv || m_rr);
    got_w = wr_ready;
    got_r = rd_ready;
    chk("wrReady", wr_ready, gw);
    chk("rdReady", rd_ready, gr);
    saddr  = fs ? 0 : m_cnt;
    due    = (cyc + 3) % 8;
    e_we   = 0;
    e_wd   = '0;
    e_addr = m_last;
    if (act) begin
      e_addr = {m_front, AW'(saddr)};
      s_pv[due] = 1;
      s_px[due] = mm[int'(m_front) * FB + saddr];
    end else if (gw) begin
      e_addr = {~m_front, wa};
      e_we = 1;
      e_wd = wd;
      mm[int'(!m_front) * FB + int'(wa)] = wd;
    end else if (gr) begin
      e_addr = {~m_front, ra};
      s_rv[due] = 1;
      s_rd[due] = mm[int'(!m_front) * FB + int'(ra)];
    end
    ack = fs && m_pend;
    @(posedge clk);
    #1;
    cyc++;
    m_front = m_front ^ ack;
    m_pend  = (m_pend && !fs) || swq;
    if (fs) m_cnt = act ? 1 : 0;
    else if (act) begin
      if (m_cnt == FB - 1) m_ovr = 1;
      else m_cnt = m_cnt + 1;
    end
    m_vsd  = vs;
    m_rr   = m_rr ^ (gw || gr);
    m_run  = 1;
    m_last = e_addr;
    chk("memAddr", mem_addr, e_addr);
    chk("memWe", mem_we, e_we);
    if (e_we) chk("memWdata", mem_wdata, e_wd);
    chk("swapAck", swap_ack, ack);
    chk("frontBank", front, m_front);
    chk("scanOverrun", overrun, m_ovr);
    idx = cyc % 8;
    chk("pixelValid", pixel_valid, s_pv[idx]);
    chk("pixel", pixel, s_pv[idx] ? s_px[idx] : '0);
    chk("rdDataValid", rd_dv, s_rv[idx]);
    if (s_rv[idx]) chk("rdData", rd_data, s_rd[idx]);
    s_pv[idx] = 0; s_rv[idx] = 0;
  endtask

  task automatic drive(input bit a, input bit v, input bit w, input bit r, input bit s);
    act = a; vs = v; wv = w; rv = r; swq = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_outA", {wr_ready, rd_ready, rd_data, rd_dv, swap_ack, front, mem_we, overrun}, '0);
    chk("reset_outB", {mem_addr, mem_wdata, pixel, pixel_valid}, '0);
    model_reset();
    drive(0, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit a; bit w; bit r; bit ew; bit er;
  } arb_vec_t;
  arb_vec_t tbl [10];

  initial begin
    bit pre_front;
    int nvalid;
    tbl[0] = '{0, 1, 1, 0, 0};
    tbl[1] = '{0, 1, 1, 1, 0};
    tbl[2] = '{0, 1, 1, 0, 1};
    tbl[3] = '{0, 1, 1, 1, 0};
    tbl[4] = '{0, 1, 1, 0, 1};
    tbl[5] = '{1, 1, 1, 0, 0};
    tbl[6] = '{0, 0, 1, 0, 1};
    tbl[7] = '{0, 1, 1, 0, 1};
    tbl[8] = '{0, 1, 0, 1, 0};
    tbl[9] = '{0, 1, 1, 0, 1};
    for (int i = 0; i < 2 * FB; i++) mm[i] = pat(i);

    #2;
    do_reset();

    // Scanout straight out of reset
    act = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("boot_addr", mem_addr, (AW+1)'(k - 1));
      chk("boot_pv", pixel_valid, k >= 3);
      chk("boot_wrReady", got_w, 0);
    end

    // Arbitration table from a fresh reset
    do_reset();
    wa = 3; ra = 9; wd = 8'h5a;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, 1, tbl[i].w, tbl[i].r, 0);
      step();
      chk("tbl_wr", got_w, tbl[i].ew);
      chk("tbl_rd", got_r, tbl[i].er);
    end
    drive(0, 1, 0, 0, 0);
    repeat (4) step();

    // Write 0xA5 to back bank addr 5, swap at frame start, scan it out
    do_reset();
    step();
    wa = 5; wd = 8'ha5;
    drive(0, 1, 1, 0, 0); step();
    drive(0, 1, 0, 0, 1); step();
    drive(0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    chk("swap_ack_pulse", swap_ack, 1);
    chk("swap_front", front, 1);
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      drive(k < 6, 1, 0, 0, 0);
      step();
      if (pixel_valid) begin
        nvalid++;
        if (nvalid == 6) chk("swap_pixel6", pixel, 8'ha5);
      end
    end
    chk("swap_npix", nvalid, 6);

    // Host write held off through 10 active cycles
    wa = 7; wd = 8'h3c;
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 1, 0, 0);
      step();
      chk("held_wrReady", got_w, 0);
    end
    drive(0, 1, 1, 0, 0);
    step();
    chk("held_accept", got_w, 1);
    chk("held_bank", mem_addr[AW], !m_front);
    chk("held_we", mem_we, 1);
    drive(0, 1, 0, 0, 0);
    repeat (3) step();

    // Swap request coinciding with frame start waits for the next one
    pre_front = m_front;
    drive(0, 0, 0, 0, 1); step();
    chk("late_swap_noack", swap_ack, 0);
    chk("late_swap_front", front, pre_front);
    drive(0, 1, 0, 0, 0); repeat (3) step();
    drive(0, 0, 0, 0, 0); step();
    chk("late_swap_ack", swap_ack, 1);
    chk("late_swap_toggle", front, !pre_front);
    drive(0, 1, 0, 0, 0); repeat (3) step();

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      act = ($urandom % 3) != 0;
      vs  = ($urandom_range(0, 30) != 0);
      wv  = $urandom % 2;
      rv  = $urandom % 2;
      swq = ($urandom % 16) == 0;
      wa  = AW'($urandom_range(0, FB - 1));
      ra  = AW'($urandom_range(0, FB - 1));
      wd  = DW'($urandom);
      step();
    end
    drive(0, 1, 0, 0, 0);
    repeat (4) step();

    // Scan overrun, then reset with a host read in flight
    do_reset();
    act = 1;
    for (int k = 0; k < FB + 1; k++) begin
      step();
      if (k == 20) chk("ovr_early", overrun, 0);
    end
    chk("ovr_addr", mem_addr[AW-1:0], FB - 1);
    chk("ovr_flag", overrun, 1);
    ra = 2;
    drive(0, 1, 0, 1, 0);
    step();
    chk("ovr_rd_accept", got_r, 1);
    drive(0, 1, 0, 0, 0);
    #2;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("no_rd_after_reset", rd_dv, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between VGA scanout and a host port. The host port supports both reads and writes. Scanout has absolute priority during the active area, and the host gets every blanking cycle. The RAM holds two banks for double buffering, and a front/back swap takes effect only at frame start (vsync falling edge). The block sits between the VGA timing generator, the framebuffer RAM and the pixel output stage.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
FB_WORDS, H_ACTIVE*V_ACTIVE, pixels per bank
ADDR_W, 19, host/bank address width (ceil log2 FB_WORDS)
DATA_W, 8, pixel width

Ports:
i_clk  in  1  pixel clock
i_reset_n  in  1  asynchronous active-low reset
i_vs  in  1  vsync from timing generator (active low)
i_activeArea  in  1  scanout slot request, high = pixel needed this cycle
i_wrValid  in  1  host write request
i_wrAddr  in  ADDR_W  host write address (back bank)
i_wrData  in  DATA_W  host write data
o_wrReady  out  1  write accepted when high with i_wrValid
i_rdValid  in  1  host read request
i_rdAddr  in  ADDR_W  host read address (back bank)
o_rdReady  out  1  read accepted when high with i_rdValid
o_rdData  out  DATA_W  host read data
o_rdDataValid  out  1  o_rdData valid, 1-cycle pulse
i_swapReq  in  1  request front/back swap (level or pulse)
o_swapAck  out  1  1-cycle pulse when swap applied
o_frontBank  out  1  bank currently scanned out
o_memAddr  out  ADDR_W+1  RAM address, MSB = bank
o_memWe  out  1  RAM write enable
o_memWdata  out  DATA_W  RAM write data
i_memRdata  in  DATA_W  RAM read data, valid 1 cycle after address
o_pixel  out  DATA_W  scanout pixel, 0 when not valid
o_pixelValid  out  1  o_pixel valid
o_scanOverrun  out  1  sticky error flag

Behaviour:
- Reset values: every output is 0. Scan counter, vs-delay register, swap-pending, front bank and RR pointer are all 0. r_running is 0 and goes to 1 on the first clock after reset release.
- Reset mid-operation: any accepted host read is discarded and no o_rdDataValid is emitted for it.
- Slot rule: each cycle has one owner.
  - Scanout owns the cycle if i_activeArea=1.
  - Otherwise the host owns it if r_running=1.
- Host arbitration:
  - o_wrReady = o_rdReady = 0 in any scanout cycle.
  - When only one host request is valid in a host cycle, that request gets ready.
  - When both are valid, a round-robin pointer picks one. The pointer toggles after each granted access and starts at write.
  - Ready is combinational from i_activeArea, the valids, r_running and the pointer.
- Memory outputs are registered; the access decided in cycle N is presented in cycle N+1.
  - Scanout: o_memAddr={front, scanCnt}, o_memWe=0.
  - Host write: o_memAddr={~front, i_wrAddr}, o_memWe=1, o_memWdata=i_wrData.
  - Host read: o_memAddr={~front, i_rdAddr}, o_memWe=0.
  - Idle: o_memWe=0, address held.
- The back bank is sampled at handshake time.
- Read return: i_memRdata is registered into o_pixel (scanout) or o_rdData (host read).
  - o_pixelValid is asserted exactly 3 cycles after the i_activeArea=1 cycle.
  - o_rdDataValid is asserted exactly 3 cycles after the read handshake.
  - A 2-bit tag pipeline (scan/read) tracks each access to its output.
- Scan counter:
  - Increments after each scanout cycle.
  - Cleared on frame start, where frame start = r_vsD=1 && i_vs=0.
  - If the counter is already FB_WORDS-1 and another scanout cycle occurs, it holds at FB_WORDS-1 and o_scanOverrun sets. Only reset clears o_scanOverrun.
- Swap:
  - i_swapReq=1 sets swapPending.
  - On frame start with swapPending=1 (registered value): front toggles, o_swapAck pulses, swapPending clears.
  - A request arriving in the same cycle as frame start is applied at the next frame start.
  - A host access handshaked in the frame-start cycle targets the pre-swap back bank.
- Frame start coinciding with i_activeArea=1: the counter clears and that scanout uses address 0.

Decomposition:
- Package vga_fb_pkg:
  - default constants H_ACTIVE, V_ACTIVE, FB_WORDS, ADDR_W, DATA_W
  - typedef fb_addr_t
  - typedef pix_t
  - enum slot_e {SLOT_IDLE, SLOT_SCAN, SLOT_HWR, SLOT_HRD}
- Sub-module vga_fb_scan_ctrl: vs edge detect, scan counter with overrun flag, and swap-pending/front-bank logic.
- Top level: arbitration, memory registers and return-tag pipeline.

Test Plan:
- Reset release with i_activeArea=1 from cycle 0:
  - o_memAddr = 0x00000, 0x00001, ... from cycle 1.
  - o_pixelValid first high on cycle 3.
  - Host readies stay 0 throughout.
- Write 0xA5 to addr 5 in blanking, swap, then scan 6 active pixels:
  - o_swapAck pulses at the vs falling edge.
  - o_pixel on the 6th valid = 0xA5.
- Write and read both valid for 4 blanking cycles:
  - Grants go W, R, W, R.
  - Each read's o_rdDataValid pulses 3 cycles after its handshake.
- Host write valid while i_activeArea=1 for 10 cycles:
  - o_wrReady=0 for all 10.
  - Accepted on the first blanking cycle.
  - No write to the front bank.
- i_swapReq in the same cycle as the vs falling edge:
  - No ack at that edge.
  - Ack and o_frontBank toggle at the next edge.
- 307201 active cycles without a vs edge: o_memAddr LSBs hold at 307199 and o_scanOverrun=1. Then assert i_reset_n=0 mid-read: all outputs 0 immediately, and no o_rdDataValid after release.
